// File: rtl/riscv_trace_pkg.sv
// Shared types for the core trace FIFO: event kinds and the packed buffer entry.
package riscv_trace_pkg;

   localparam int unsigned TRACE_DATA_W = 32;
   localparam int unsigned TRACE_TS_W   = 16;
   localparam int unsigned TRACE_IDX_W  = 9;

   typedef enum logic [1:0] {
      TR_REG = 2'b00,
      TR_MRD = 2'b01,
      TR_MWR = 2'b10
   } trace_type_e;

   typedef struct packed {
      trace_type_e              typ;
      logic [TRACE_IDX_W-1:0]   idx;
      logic [TRACE_DATA_W-1:0]  data;
      logic [TRACE_TS_W-1:0]    ts;
   } trace_entry_t;

endpackage

// File: rtl/trace_ram_2w1r.sv
// Trace entry storage: two write ports on consecutive slots, one asynchronous read port.
module trace_ram_2w1r
   import riscv_trace_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we0,
   input  logic             we1,
   input  logic [PTR_W-1:0] waddr,
   input  trace_entry_t     wdata0,
   input  trace_entry_t     wdata1,
   input  logic [PTR_W-1:0] raddr,
   output trace_entry_t     rdata
);

   trace_entry_t mem [DEPTH];

   // Port 1 always targets the slot after port 0; pointer wraps naturally.
   always_ff @(posedge clk) begin
      if (we0) mem[waddr] <= wdata0;
      if (we1) mem[PTR_W'(waddr + PTR_W'(1))] <= wdata1;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/riscv_trace_fifo.sv
// Captures core writeback and data-memory events as timestamped entries and
// buffers them for a valid/ready host, dropping (and counting) what does not fit.
module riscv_trace_fifo
   import riscv_trace_pkg::*;
#(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned DATA_W    = TRACE_DATA_W,
   parameter int unsigned TS_W      = TRACE_TS_W,
   parameter bit          FILTER_X0 = 1'b1,
   localparam int unsigned LVL_W    = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              trace_en,
   input  logic              reg_write_sig,
   input  logic [4:0]        reg_num,
   input  logic [DATA_W-1:0] reg_data,
   input  logic              wr,
   input  logic              rd,
   input  logic [8:0]        addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [1:0]        out_type,
   output logic [8:0]        out_idx,
   output logic [DATA_W-1:0] out_data,
   output logic [TS_W-1:0]   out_ts,
   output logic [LVL_W-1:0]  level,
   output logic [15:0]       drop_count,
   output logic              overflow
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned FREE_W = LVL_W + 1;

   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]  level_q;
   logic [TS_W-1:0]   ts_q;
   logic [15:0]       drop_q;
   logic              overflow_q;

   logic              ev_r_c, ev_m_c, pop_c;
   logic [FREE_W-1:0] free_c;
   logic [1:0]        n_push_c, n_drop_c;
   logic [16:0]       drop_sum_c;
   trace_entry_t      entry_r_c, entry_m_c, wdata0_c, head_c;

   // Event decode and entry packing for the current cycle.
   always_comb begin
      ev_r_c = trace_en && reg_write_sig && !(FILTER_X0 && (reg_num == 5'd0));
      ev_m_c = trace_en && (wr || rd);

      entry_r_c.typ  = TR_REG;
      entry_r_c.idx  = TRACE_IDX_W'(reg_num);
      entry_r_c.data = TRACE_DATA_W'(reg_data);
      entry_r_c.ts   = TRACE_TS_W'(ts_q);

      entry_m_c.typ  = wr ? TR_MWR : TR_MRD;
      entry_m_c.idx  = addr;
      entry_m_c.data = wr ? TRACE_DATA_W'(wr_data) : TRACE_DATA_W'(rd_data);
      entry_m_c.ts   = TRACE_TS_W'(ts_q);
   end

   assign pop_c  = out_valid && out_ready;
   assign free_c = FREE_W'(DEPTH) - FREE_W'(level_q) + FREE_W'(pop_c);

   // Push/drop arbitration; the register event is older and wins the last slot.
   always_comb begin
      n_push_c = 2'd0;
      n_drop_c = 2'd0;
      wdata0_c = entry_r_c;
      if (ev_r_c && ev_m_c) begin
         if (free_c >= FREE_W'(2)) begin
            n_push_c = 2'd2;
         end else if (free_c == FREE_W'(1)) begin
            n_push_c = 2'd1;
            n_drop_c = 2'd1;
         end else begin
            n_drop_c = 2'd2;
         end
      end else if (ev_r_c || ev_m_c) begin
         wdata0_c = ev_r_c ? entry_r_c : entry_m_c;
         if (free_c >= FREE_W'(1)) n_push_c = 2'd1;
         else                      n_drop_c = 2'd1;
      end
   end

   assign drop_sum_c = {1'b0, drop_q} + 17'(n_drop_c);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         ts_q       <= '0;
         drop_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         ts_q       <= ts_q + TS_W'(1);
         wr_ptr_q   <= wr_ptr_q + PTR_W'(n_push_c);
         rd_ptr_q   <= rd_ptr_q + PTR_W'(pop_c);
         level_q    <= level_q + LVL_W'(n_push_c) - LVL_W'(pop_c);
         drop_q     <= drop_sum_c[16] ? 16'hFFFF : drop_sum_c[15:0];
         overflow_q <= overflow_q | (n_drop_c != 2'd0);
      end
   end

   trace_ram_2w1r #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_ram (
      .clk    (clk),
      .we0    (n_push_c != 2'd0),
      .we1    (n_push_c == 2'd2),
      .waddr  (wr_ptr_q),
      .wdata0 (wdata0_c),
      .wdata1 (entry_m_c),
      .raddr  (rd_ptr_q),
      .rdata  (head_c)
   );

   // Head fields are forced to zero while empty so stale storage never shows.
   assign out_valid  = (level_q != '0);
   assign out_type   = out_valid ? head_c.typ : 2'b00;
   assign out_idx    = out_valid ? head_c.idx : 9'd0;
   assign out_data   = out_valid ? DATA_W'(head_c.data) : '0;
   assign out_ts     = out_valid ? TS_W'(head_c.ts) : '0;
   assign level      = level_q;
   assign drop_count = drop_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_riscv_trace_fifo.sv
// Randomized bench for riscv_trace_fifo against a queue-based reference model.
module tb_riscv_trace_fifo;

   localparam int unsigned DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        trace_en, reg_write_sig, wr, rd, out_ready;
   logic [4:0]  reg_num;
   logic [31:0] reg_data, wr_data, rd_data;
   logic [8:0]  addr;
   logic        out_valid, overflow;
   logic [1:0]  out_type;
   logic [8:0]  out_idx;
   logic [31:0] out_data;
   logic [15:0] out_ts, drop_count;
   logic [4:0]  level;

   always #5 clk = ~clk;

   riscv_trace_fifo dut (
      .clk           (clk),
      .reset         (reset),
      .trace_en      (trace_en),
      .reg_write_sig (reg_write_sig),
      .reg_num       (reg_num),
      .reg_data      (reg_data),
      .wr            (wr),
      .rd            (rd),
      .addr          (addr),
      .wr_data       (wr_data),
      .rd_data       (rd_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_type      (out_type),
      .out_idx       (out_idx),
      .out_data      (out_data),
      .out_ts        (out_ts),
      .level         (level),
      .drop_count    (drop_count),
      .overflow      (overflow)
   );

   typedef struct packed {
      logic [1:0]  t;
      logic [8:0]  idx;
      logic [31:0] d;
      logic [15:0] ts;
   } ent_t;

   ent_t        q[$];
   logic [15:0] m_ts;
   int          m_drops;
   bit          m_ovf;
   int          vectors = 0;
   int          miscompares = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_state();
      check_eq("out_valid", 64'(out_valid), 64'(q.size() != 0));
      check_eq("level", 64'(level), 64'(q.size()));
      check_eq("drop_count", 64'(drop_count), 64'(m_drops));
      check_eq("overflow", 64'(overflow), 64'(m_ovf));
      if (q.size() != 0) begin
         check_eq("out_type", 64'(out_type), 64'(q[0].t));
         check_eq("out_idx", 64'(out_idx), 64'(q[0].idx));
         check_eq("out_data", 64'(out_data), 64'(q[0].d));
         check_eq("out_ts", 64'(out_ts), 64'(q[0].ts));
      end else begin
         check_eq("empty_fields", {out_type, out_idx, out_data, out_ts}, 64'd0);
      end
   endtask

   // One clock of the reference: pop first, then place events oldest-first into free slots.
   task automatic model_step(input logic en, input logic rws, input logic [4:0] rn,
                             input logic [31:0] rdat, input logic w, input logic r,
                             input logic [8:0] a, input logic [31:0] wd,
                             input logic [31:0] rdd, input logic rdy);
      ent_t ev[$];
      int   free;
      int   dropped = 0;
      if (en && rws && rn != 5'd0) ev.push_back(ent_t'{t: 2'b00, idx: 9'(rn), d: rdat, ts: m_ts});
      if (en && w)      ev.push_back(ent_t'{t: 2'b10, idx: a, d: wd, ts: m_ts});
      else if (en && r) ev.push_back(ent_t'{t: 2'b01, idx: a, d: rdd, ts: m_ts});
      if (rdy && q.size() != 0) void'(q.pop_front());
      free = DEPTH - q.size();
      foreach (ev[i]) begin
         if (free > 0) begin
            q.push_back(ev[i]);
            free--;
         end else begin
            dropped++;
         end
      end
      m_drops = (m_drops + dropped > 65535) ? 65535 : m_drops + dropped;
      if (dropped > 0) m_ovf = 1'b1;
      m_ts = m_ts + 16'd1;
   endtask

   task automatic drive(input logic en, input logic rws, input logic [4:0] rn,
                        input logic [31:0] rdat, input logic w, input logic r,
                        input logic [8:0] a, input logic [31:0] wd,
                        input logic [31:0] rdd, input logic rdy);
      check_state();
      trace_en = en; reg_write_sig = rws; reg_num = rn; reg_data = rdat;
      wr = w; rd = r; addr = a; wr_data = wd; rd_data = rdd; out_ready = rdy;
      model_step(en, rws, rn, rdat, w, r, a, wd, rdd, rdy);
      @(negedge clk);
   endtask

   task automatic idle(input logic rdy);
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 9'd0, 32'd0, 32'd0, rdy);
   endtask

   task automatic drive_rand(input int ready_pct);
      logic [4:0] rn;
      rn = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      drive($urandom_range(0, 9) != 0, 1'($urandom), rn, $urandom,
            $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0, 9'($urandom),
            $urandom, $urandom, $urandom_range(0, 99) < ready_pct);
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 2 && q.size() != 0; i++) idle(1'b1);
      check_eq("drained_level", 64'(level), 64'd0);
   endtask

   initial begin
      reset = 1'b1;
      trace_en = 0; reg_write_sig = 0; reg_num = 0; reg_data = 0;
      wr = 0; rd = 0; addr = 0; wr_data = 0; rd_data = 0; out_ready = 0;
      m_ts = 16'd0; m_drops = 0; m_ovf = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Single register write at ts=3, popped immediately.
      repeat (3) idle(1'b1);
      drive(1, 1, 5'd5, 32'hDEADBEEF, 0, 0, 9'd0, 32'd0, 32'd0, 1);
      check_eq("t1_valid", 64'(out_valid), 64'd1);
      check_eq("t1_data", 64'(out_data), 64'hDEADBEEF);
      check_eq("t1_ts", 64'(out_ts), 64'd3);
      idle(1'b1);
      check_eq("t1_level", 64'(level), 64'd0);

      // Same-cycle register and memory write: register first.
      drive(1, 1, 5'd7, 32'h11, 1, 0, 9'h040, 32'h22, 32'd0, 0);
      check_eq("t2_level", 64'(level), 64'd2);
      check_eq("t2_head_idx", 64'(out_idx), 64'd7);
      idle(1'b1);
      check_eq("t2_second_type", 64'(out_type), 64'd2);
      check_eq("t2_second_data", 64'(out_data), 64'h22);
      idle(1'b1);

      // Fill past capacity with single events.
      for (int i = 0; i < 19; i++) drive(1, 0, 5'd0, 32'd0, 1, 0, 9'(i), $urandom, 32'd0, 0);
      check_eq("t3_level", 64'(level), 64'd16);
      check_eq("t3_drops", 64'(drop_count), 64'd3);
      check_eq("t3_overflow", 64'(overflow), 64'd1);
      check_eq("t3_head_idx", 64'(out_idx), 64'd0);

      // One free slot: register kept, memory dropped; then again with a pop.
      idle(1'b1);
      drive(1, 1, 5'd9, 32'hA5, 0, 1, 9'h1FF, 32'd0, 32'h5A, 0);
      check_eq("t4_level", 64'(level), 64'd16);
      check_eq("t4_drops", 64'(drop_count), 64'd4);
      drive(1, 1, 5'd10, 32'hB6, 1, 0, 9'h1, 32'h6B, 32'd0, 1);
      check_eq("t4b_level", 64'(level), 64'd16);
      check_eq("t4b_drops", 64'(drop_count), 64'd5);
      drain();

      // x0 filtering and combined read/write strobe.
      drive(1, 1, 5'd0, 32'h1234, 0, 0, 9'd0, 32'd0, 32'd0, 0);
      check_eq("t5_x0_level", 64'(level), 64'd0);
      drive(1, 0, 5'd0, 32'd0, 1, 1, 9'h12, 32'hCAFE, 32'hBEEF, 0);
      check_eq("t5_rw_level", 64'(level), 64'd1);
      check_eq("t5_rw_type", 64'(out_type), 64'd2);
      drain();

      // Randomized traffic with varying back-pressure.
      for (int i = 0; i < 600; i++) drive_rand(30);
      for (int i = 0; i < 600; i++) drive_rand(90);
      for (int i = 0; i < 600; i++) drive_rand(60);
      drain();

      // Asynchronous reset mid-stream at level 9.
      for (int i = 0; i < 9; i++) drive(1, 1, 5'(i + 1), $urandom, 0, 0, 9'd0, 32'd0, 32'd0, 0);
      check_eq("t7_level_pre", 64'(level), 64'd9);
      #2 reset = 1'b1;
      #1;
      check_eq("t7_valid", 64'(out_valid), 64'd0);
      check_eq("t7_level", 64'(level), 64'd0);
      check_eq("t7_drops", 64'(drop_count), 64'd0);
      check_eq("t7_overflow", 64'(overflow), 64'd0);
      trace_en = 0; reg_write_sig = 0; wr = 0; rd = 0; out_ready = 0;
      q.delete();
      m_ts = 16'd0; m_drops = 0; m_ovf = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      // Timestamp wrap across 16'hFFFF.
      for (int i = 0; i < 70000 && m_ts != 16'hFFFE; i++) idle(1'b1);
      drive(1, 1, 5'd3, 32'h1, 0, 0, 9'd0, 32'd0, 32'd0, 0);
      drive(1, 1, 5'd4, 32'h2, 0, 0, 9'd0, 32'd0, 32'd0, 0);
      drive(1, 1, 5'd5, 32'h3, 0, 0, 9'd0, 32'd0, 32'd0, 0);
      check_eq("t8_ts0", 64'(out_ts), 64'hFFFE);
      idle(1'b1);
      check_eq("t8_ts1", 64'(out_ts), 64'hFFFF);
      idle(1'b1);
      check_eq("t8_ts2", 64'(out_ts), 64'h0);
      idle(1'b1);
      idle(1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
